// File: rtl/vend_credit_ctrl.sv
// Credit-accumulating vending controller: accepts coins, issues a dispense strobe, returns change in
// UNIT-sized pulses. Define VEND_TIMEOUT_EN to enable the idle auto-refund in ACCUM.
module vend_credit_ctrl #(
   parameter int unsigned PRICE   = 30,
   parameter int unsigned UNIT    = 5,
   parameter int unsigned COIN_A  = 5,
   parameter int unsigned COIN_B  = 10,
   parameter int unsigned COIN_C  = 25,
   parameter int unsigned CW      = 6,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_coin_valid,
   input  logic [1:0]    i_coin_sel,
   output logic          o_dispense,
   output logic          o_change_pulse,
   output logic          o_coin_reject,
   output logic          o_busy,
   output logic [CW-1:0] o_credit
);

   localparam int unsigned MaxCoin = (COIN_A > COIN_B) ? ((COIN_A > COIN_C) ? COIN_A : COIN_C)
                                                       : ((COIN_B > COIN_C) ? COIN_B : COIN_C);

   if (UNIT == 0 || PRICE == 0 || TIMEOUT < 2 || (PRICE % UNIT) != 0 || (COIN_A % UNIT) != 0 ||
       (COIN_B % UNIT) != 0 || (COIN_C % UNIT) != 0) begin : g_bad_values
      $error("vend_credit_ctrl: PRICE/coins must be non-zero multiples of UNIT, TIMEOUT >= 2");
   end
   if ((1 << CW) <= (PRICE - UNIT + MaxCoin)) begin : g_bad_width
      $error("vend_credit_ctrl: CW too small for PRICE - UNIT + largest coin");
   end

   localparam logic [CW:0]   PriceW = (CW+1)'(PRICE);
   localparam logic [CW:0]   CoinAW = (CW+1)'(COIN_A);
   localparam logic [CW:0]   CoinBW = (CW+1)'(COIN_B);
   localparam logic [CW:0]   CoinCW = (CW+1)'(COIN_C);
   localparam logic [CW-1:0] PriceN = CW'(PRICE);
   localparam logic [CW-1:0] UnitN  = CW'(UNIT);

   typedef enum logic [1:0] {StIdle, StAccum, StVend, StReturn} state_e;

   state_e        r_state;
   state_e        w_state_nxt;
   logic [CW-1:0] r_credit;
   logic [CW-1:0] w_credit_nxt;
   logic          r_dispense;
   logic          r_change_pulse;
   logic          r_coin_reject;
   logic          r_busy;

   logic          w_coin;
   logic          w_cancel;
   logic [CW:0]   w_coin_val;
   logic [CW:0]   w_sum;
   logic [CW-1:0] w_excess;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT);
   logic [TW-1:0] r_idle_cnt;
   logic [TW-1:0] w_idle_cnt_nxt;
`endif

   assign w_coin   = i_coin_valid && (i_coin_sel != 2'b00);
   assign w_cancel = i_coin_valid && (i_coin_sel == 2'b00);

   always_comb begin
      w_coin_val = '0;
      case (i_coin_sel)
         2'b01:   w_coin_val = CoinAW;
         2'b10:   w_coin_val = CoinBW;
         2'b11:   w_coin_val = CoinCW;
         default: w_coin_val = '0;
      endcase
   end

   // Compare in CW+1 bits; the excess always fits in CW bits, so the low-bit subtract is exact.
   assign w_sum    = {1'b0, r_credit} + w_coin_val;
   assign w_excess = w_sum[CW-1:0] - PriceN;

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
`ifdef VEND_TIMEOUT_EN
      w_idle_cnt_nxt = r_idle_cnt;
`endif
      unique case (r_state)
         StIdle, StAccum: begin
            if (w_coin) begin
`ifdef VEND_TIMEOUT_EN
               w_idle_cnt_nxt = '0;
`endif
               if (w_sum >= PriceW) begin
                  w_credit_nxt = w_excess;
                  w_state_nxt  = StVend;
               end else begin
                  w_credit_nxt = w_sum[CW-1:0];
                  w_state_nxt  = StAccum;
               end
            end else if (w_cancel && r_state == StAccum) begin
               w_state_nxt = StReturn;
            end
`ifdef VEND_TIMEOUT_EN
            else if (r_state == StAccum) begin
               if (r_idle_cnt == TW'(TIMEOUT - 1)) begin
                  w_state_nxt = StReturn;
               end else begin
                  w_idle_cnt_nxt = r_idle_cnt + 1'b1;
               end
            end
`endif
         end
         StVend: begin
            w_state_nxt = (r_credit == '0) ? StIdle : StReturn;
         end
         StReturn: begin
            w_credit_nxt = r_credit - UnitN;
            if (r_credit == UnitN) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt  = StIdle;
            w_credit_nxt = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= StIdle;
         r_credit       <= '0;
         r_dispense     <= 1'b0;
         r_change_pulse <= 1'b0;
         r_coin_reject  <= 1'b0;
         r_busy         <= 1'b0;
`ifdef VEND_TIMEOUT_EN
         r_idle_cnt     <= '0;
`endif
      end else begin
         r_state        <= w_state_nxt;
         r_credit       <= w_credit_nxt;
         r_dispense     <= (w_state_nxt == StVend);
         r_change_pulse <= (w_state_nxt == StReturn);
         r_busy         <= (w_state_nxt == StVend) || (w_state_nxt == StReturn);
         r_coin_reject  <= w_coin && ((r_state == StVend) || (r_state == StReturn));
`ifdef VEND_TIMEOUT_EN
         r_idle_cnt     <= w_idle_cnt_nxt;
`endif
      end
   end

   assign o_dispense     = r_dispense;
   assign o_change_pulse = r_change_pulse;
   assign o_coin_reject  = r_coin_reject;
   assign o_busy         = r_busy;
   assign o_credit       = r_credit;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios plus random coins, all compared each
// cycle against a credit/refund reference model.
module tb_vend_credit_ctrl;

   localparam int unsigned PRICE   = 30;
   localparam int unsigned UNIT    = 5;
   localparam int unsigned COIN_A  = 5;
   localparam int unsigned COIN_B  = 10;
   localparam int unsigned COIN_C  = 25;
   localparam int unsigned CW      = 6;
   localparam int unsigned TIMEOUT = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          coin_valid;
   logic [1:0]    coin_sel;
   logic          dispense;
   logic          change_pulse;
   logic          coin_reject;
   logic          busy;
   logic [CW-1:0] credit;

   always #5 clk = ~clk;

   vend_credit_ctrl #(
      .PRICE   (PRICE),
      .UNIT    (UNIT),
      .COIN_A  (COIN_A),
      .COIN_B  (COIN_B),
      .COIN_C  (COIN_C),
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_coin_valid   (coin_valid),
      .i_coin_sel     (coin_sel),
      .o_dispense     (dispense),
      .o_change_pulse (change_pulse),
      .o_coin_reject  (coin_reject),
      .o_busy         (busy),
      .o_credit       (credit)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: credit held, a pending sale, and whether change is being paid out.
   int m_credit;
   bit m_vend;
   bit m_paying;
   bit m_reject;
   int m_idle;

   int n_disp;
   int n_pulse;
   int n_rej;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int coin_value(input logic [1:0] s);
      case (s)
         2'b01:   return COIN_A;
         2'b10:   return COIN_B;
         2'b11:   return COIN_C;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_credit = 0;
      m_vend   = 0;
      m_paying = 0;
      m_reject = 0;
      m_idle   = 0;
   endtask

   task automatic model_step(input bit v, input logic [1:0] s);
      bit was_busy;
      was_busy = m_vend || m_paying;
      m_reject = v && (s != 2'b00) && was_busy;
      if (m_vend) begin
         m_vend   = 0;
         m_paying = (m_credit > 0);
      end else if (m_paying) begin
         m_credit -= UNIT;
         m_paying = (m_credit > 0);
      end else if (v && s != 2'b00) begin
         m_idle   = 0;
         m_credit += coin_value(s);
         if (m_credit >= PRICE) begin
            m_credit -= PRICE;
            m_vend   = 1;
         end
      end else if (m_credit > 0) begin
         if (v) m_paying = 1;
`ifdef VEND_TIMEOUT_EN
         else if (m_idle == TIMEOUT - 1) m_paying = 1;
         else m_idle++;
`endif
      end
   endtask

   task automatic check_outputs();
      check_eq("dispense", dispense, m_vend);
      check_eq("change_pulse", change_pulse, m_paying);
      check_eq("busy", busy, m_vend || m_paying);
      check_eq("coin_reject", coin_reject, m_reject);
      check_eq("credit", credit, m_credit);
      n_disp  += dispense;
      n_pulse += change_pulse;
      n_rej   += coin_reject;
   endtask

   task automatic tick(input bit v, input logic [1:0] s);
      coin_valid = v;
      coin_sel   = s;
      @(posedge clk);
      model_step(v, s);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic clear_tally();
      n_disp  = 0;
      n_pulse = 0;
      n_rej   = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 2'b00);
         if (!(m_vend || m_paying)) break;
      end
      check_eq("drain_idle", busy, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      coin_valid = 1'b0;
      coin_sel   = 2'b00;
      model_reset();
      clear_tally();
      #12;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b0, 2'b00);

      // 10,10,10: exact price
      clear_tally();
      repeat (3) tick(1'b1, 2'b10);
      check_eq("exact_dispense_now", dispense, 1);
      drain();
      check_eq("exact_disp", n_disp, 1);
      check_eq("exact_pulses", n_pulse, 0);

      // 10,10,25: excess 15
      clear_tally();
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b11);
      check_eq("excess_credit", credit, 15);
      drain();
      check_eq("excess_disp", n_disp, 1);
      check_eq("excess_pulses", n_pulse, 3);
      check_eq("excess_final_credit", credit, 0);

      // 5,10 then cancel
      clear_tally();
      tick(1'b1, 2'b01);
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b00);
      drain();
      check_eq("cancel_disp", n_disp, 0);
      check_eq("cancel_pulses", n_pulse, 3);
      check_eq("cancel_credit", credit, 0);

      // Coin offered during change return
      clear_tally();
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b11);
      tick(1'b0, 2'b00);
      tick(1'b1, 2'b11);
      check_eq("reject_pulse", coin_reject, 1);
      drain();
      check_eq("reject_pulses", n_pulse, 3);
      check_eq("reject_count", n_rej, 1);

      // Asynchronous reset mid-return
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b10);
      tick(1'b1, 2'b11);
      tick(1'b0, 2'b00);
      check_eq("pre_reset_pulse", change_pulse, 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b0, 2'b00);
      check_eq("post_reset_busy", busy, 0);

`ifdef VEND_TIMEOUT_EN
      // Auto-refund after TIMEOUT idle cycles
      clear_tally();
      tick(1'b1, 2'b10);
      repeat (TIMEOUT + 4) tick(1'b0, 2'b00);
      check_eq("timeout_pulses", n_pulse, 2);
      // Coin on the timeout edge wins
      clear_tally();
      tick(1'b1, 2'b01);
      repeat (TIMEOUT - 1) tick(1'b0, 2'b00);
      tick(1'b1, 2'b01);
      check_eq("timeout_coin_credit", credit, 10);
      check_eq("timeout_coin_busy", busy, 0);
      tick(1'b1, 2'b00);
      drain();
      check_eq("timeout_coin_pulses", n_pulse, 2);
`endif

      // Randomized coins, cancels and idle gaps
      for (int i = 0; i < 600; i++) begin
         logic [1:0] s;
         bit         v;
         v = ($urandom_range(0, 2) == 0);
         s = 2'($urandom_range(0, 3));
         tick(v, s);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
